// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx between NUM_REQ byte producers.
// Optional line locking is compiled in by defining UART_TX_ARB_LOCK_EN.
module uart_tx_arb #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_CHAR    = 8'h0A,
   parameter int LOCK_TIMEOUT = 100000
) (
   input  logic                 clk,
   input  logic                 reset_,
   input  logic [NUM_REQ-1:0]   req,
   output logic [NUM_REQ-1:0]   ready,
   input  logic [8*NUM_REQ-1:0] data,
   output logic                 tx_req,
   input  logic                 tx_ready,
   output logic [7:0]           tx_data,
   output logic [2:0]           owner,
   output logic                 locked
);

   if (NUM_REQ < 2 || NUM_REQ > 8 || LOCK_CHAR < 0 || LOCK_CHAR > 255 ||
       LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 1048575) begin : g_bad_param
      $error("uart_tx_arb: illegal parameter value");
   end

   // Handshake on both sides: a byte moves on a rising edge with req and ready both high;
   // the sender holds req/data stable until then, and req never depends on ready.
   logic               r_tx_req;
   logic [7:0]         r_tx_data;
   logic [2:0]         r_owner;
   logic               w_can_load;
   logic               w_found;
   logic               w_accept;
   logic [2:0]         w_win;
   logic [7:0]         w_byte;
   logic [NUM_REQ-1:0] w_owner_oh;
   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_ready;

   always_comb begin
      w_owner_oh = '0;
      for (int i = 0; i < NUM_REQ; i++)
         w_owner_oh[i] = (r_owner == 3'(i));
   end

   assign w_elig     = locked ? (req & w_owner_oh) : req;
   assign w_can_load = !r_tx_req || tx_ready;

   // Lowest index at or below owner first, then overridden by the lowest index above
   // owner, giving the search order owner+1 .. NUM_REQ-1, 0 .. owner.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_elig[i] && (3'(i) <= r_owner)) begin
            w_found = 1'b1;
            w_win   = 3'(i);
         end
      end
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_elig[i] && (3'(i) > r_owner)) begin
            w_found = 1'b1;
            w_win   = 3'(i);
         end
      end
   end

   always_comb begin
      w_ready = '0;
      w_byte  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == 3'(i)) begin
            w_byte     = data[8*i +: 8];
            w_ready[i] = w_found && w_can_load && reset_;
         end
      end
   end

   assign w_accept = |w_ready;

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_tx_req  <= 1'b0;
         r_tx_data <= 8'h00;
         r_owner   <= 3'(NUM_REQ - 1);
      end else if (w_accept) begin
         r_tx_req  <= 1'b1;
         r_tx_data <= w_byte;
         r_owner   <= w_win;
      end else if (tx_ready) begin
         r_tx_req  <= 1'b0;
      end
   end

`ifdef UART_TX_ARB_LOCK_EN
   localparam logic [7:0]  LOCK_BYTE = 8'(LOCK_CHAR);
   localparam logic [19:0] CNT_LAST  = 20'(LOCK_TIMEOUT - 1);

   logic        r_locked;
   logic [19:0] r_lock_cnt;
   logic        w_owner_req;

   assign w_owner_req = |(req & w_owner_oh);

   // While locked only the owner can be accepted, so any accept refreshes the lock.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_locked   <= 1'b0;
         r_lock_cnt <= '0;
      end else if (w_accept) begin
         r_locked   <= (w_byte != LOCK_BYTE);
         r_lock_cnt <= '0;
      end else if (r_locked && !w_owner_req) begin
         if (r_lock_cnt == CNT_LAST) begin
            r_locked   <= 1'b0;
            r_lock_cnt <= '0;
         end else begin
            r_lock_cnt <= r_lock_cnt + 20'd1;
         end
      end
   end

   assign locked = r_locked;
`else
   assign locked = 1'b0;
`endif

   assign ready   = w_ready;
   assign tx_req  = r_tx_req;
   assign tx_data = r_tx_data;
   assign owner   = r_owner;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Testbench for uart_tx_arb: table-driven single-cycle vectors plus hand-written
// multi-cycle sequences (reset mid-transfer, message interleave/lock, lock timeout).
module tb_uart_tx_arb;

   localparam int N = 4;

   logic          clk = 1'b0;
   logic          reset_;
   logic [N-1:0]  req;
   logic [N-1:0]  ready;
   logic [8*N-1:0] data;
   logic          tx_req;
   logic          tx_ready;
   logic [7:0]    tx_data;
   logic [2:0]    owner;
   logic          locked;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [N-1:0]   req;
      logic           tx_ready;
      logic [8*N-1:0] data;
      logic [N-1:0]   exp_ready;
      logic           exp_tx_req;
      logic [7:0]     exp_tx_data;
      logic [2:0]     exp_owner;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] exp_q[$];
   logic       exp_lock_q[$];

   uart_tx_arb #(
      .NUM_REQ      (N),
      .LOCK_CHAR    (8'h0A),
      .LOCK_TIMEOUT (16)
   ) dut (
      .clk      (clk),
      .reset_   (reset_),
      .req      (req),
      .ready    (ready),
      .data     (data),
      .tx_req   (tx_req),
      .tx_ready (tx_ready),
      .tx_data  (tx_data),
      .owner    (owner),
      .locked   (locked)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic [N-1:0] r, input logic tr, input logic [8*N-1:0] d,
                      input logic [N-1:0] er, input logic etq, input logic [7:0] etd,
                      input logic [2:0] eo);
      vec_t v;
      v.req = r; v.tx_ready = tr; v.data = d;
      v.exp_ready = er; v.exp_tx_req = etq; v.exp_tx_data = etd; v.exp_owner = eo;
      vecs.push_back(v);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_ = 1'b0;
      req = '0; tx_ready = 1'b1; data = '0;
      @(negedge clk);
      reset_ = 1'b1;
   endtask

   // Accept one LOCK_CHAR byte from requester 0 so owner is 0 and no lock is held.
   task automatic prime_owner0();
      @(negedge clk);
      req = 4'b0001; tx_ready = 1'b1; data = 32'h0000_000A;
      @(posedge clk);
      #1;
      check("prime_owner", 32'(owner), 32'd0);
      @(negedge clk);
      req = '0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0]   msg [3];
      logic [N-1:0] r_rdy;
      int           m;
      int           cyc;

      reset_ = 1'b0; req = '1; tx_ready = 1'b1; data = 32'h0302_0100;
      repeat (2) @(posedge clk);
      #1;
      check("rst_tx_req",  32'(tx_req),  32'd0);
      check("rst_tx_data", 32'(tx_data), 32'h00);
      check("rst_ready",   32'(ready),   32'd0);
      check("rst_owner",   32'(owner),   32'd3);
      check("rst_locked",  32'(locked),  32'd0);
      @(negedge clk);
      reset_ = 1'b1; req = '0;

`ifndef UART_TX_ARB_LOCK_EN
      // Round-robin from reset: 00,01,02,03,00 back to back.
      for (int i = 0; i < 5; i++)
         add(4'hF, 1'b1, 32'h0302_0100, 4'(1 << (i % 4)), 1'b1, 8'(i % 4), 3'(i % 4));
      add(4'h0, 1'b1, 32'h0302_0100, 4'h0, 1'b0, 8'h00, 3'd0);
`endif
      // Backpressure: one accept, held for 10 stalled cycles, then drain and refill.
      add(4'b0100, 1'b0, 32'h00A5_0000, 4'b0100, 1'b1, 8'hA5, 3'd2);
      for (int i = 0; i < 9; i++)
         add(4'b0100, 1'b0, 32'h005A_0000, 4'b0000, 1'b1, 8'hA5, 3'd2);
      add(4'b0100, 1'b1, 32'h005A_0000, 4'b0100, 1'b1, 8'h5A, 3'd2);
      add(4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 8'h5A, 3'd2);
`ifndef UART_TX_ARB_LOCK_EN
      // Search order and wrap-around from various owners.
      add(4'b0011, 1'b1, 32'h3322_1100, 4'b0001, 1'b1, 8'h00, 3'd0);
      add(4'b0011, 1'b1, 32'h3322_1100, 4'b0010, 1'b1, 8'h11, 3'd1);
      add(4'b0010, 1'b1, 32'h3322_1200, 4'b0010, 1'b1, 8'h12, 3'd1);
      add(4'b1001, 1'b1, 32'h3322_1200, 4'b1000, 1'b1, 8'h33, 3'd3);
      add(4'b1001, 1'b1, 32'h3322_1200, 4'b0001, 1'b1, 8'h00, 3'd0);
      add(4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 3'd0);
`endif

      foreach (vecs[i]) begin
         @(negedge clk);
         req = vecs[i].req; tx_ready = vecs[i].tx_ready; data = vecs[i].data;
         #1;
         check($sformatf("v%0d_ready", i), 32'(ready), 32'(vecs[i].exp_ready));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_tx_req", i),  32'(tx_req),  32'(vecs[i].exp_tx_req));
         check($sformatf("v%0d_tx_data", i), 32'(tx_data), 32'(vecs[i].exp_tx_data));
         check($sformatf("v%0d_owner", i),   32'(owner),   32'(vecs[i].exp_owner));
      end

      // Asynchronous reset while a byte is held.
      @(negedge clk);
      req = 4'b0100; tx_ready = 1'b0; data = 32'h0077_0000;
      @(posedge clk);
      #1;
      check("pre_rst_tx_req", 32'(tx_req), 32'd1);
      @(negedge clk);
      req = '1;
      #2;
      reset_ = 1'b0;
      #1;
      check("mid_rst_tx_req",  32'(tx_req),  32'd0);
      check("mid_rst_ready",   32'(ready),   32'd0);
      check("mid_rst_locked",  32'(locked),  32'd0);
      check("mid_rst_owner",   32'(owner),   32'd3);
      check("mid_rst_tx_data", 32'(tx_data), 32'h00);
      @(negedge clk);
      reset_ = 1'b1; tx_ready = 1'b1; data = 32'h0302_010A;
      #1;
      check("post_rst_ready", 32'(ready), 32'b0001);
      @(posedge clk);
      #1;
      check("post_rst_tx_data", 32'(tx_data), 32'h0A);
      check("post_rst_owner",   32'(owner),   32'd0);
      @(negedge clk);
      req = '0;
      @(posedge clk);
      #1;

      // Message "AB\n" from requester 1 against a continuously requesting requester 0.
      msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h0A;
`ifdef UART_TX_ARB_LOCK_EN
      exp_q = '{8'h41, 8'h42, 8'h0A, 8'h30};
      exp_lock_q = '{1'b1, 1'b1, 1'b0, 1'b1};
`else
      exp_q = '{8'h41, 8'h30, 8'h42, 8'h30, 8'h0A};
      exp_lock_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
      m = 0;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 30) begin
         @(negedge clk);
         req = {2'b00, (m < 3), 1'b1};
         data = {16'h0000, (m < 3) ? msg[m] : 8'h00, 8'h30};
         #1;
         r_rdy = ready;
         @(posedge clk);
         #1;
         if (r_rdy != '0) begin
            check("msg_byte",   32'(tx_data), 32'(exp_q.pop_front()));
            check("msg_locked", 32'(locked),  32'(exp_lock_q.pop_front()));
            if (r_rdy[1]) m++;
         end
         cyc++;
      end
      check("msg_complete", 32'(exp_q.size()), 32'd0);

`ifdef UART_TX_ARB_LOCK_EN
      // Lock timeout: requester 1 sends one byte then goes idle while requester 3 waits.
      do_reset();
      prime_owner0();
      @(negedge clk);
      req = 4'b1010; data = 32'h3300_4100; tx_ready = 1'b1;
      #1;
      check("to_first_ready", 32'(ready), 32'b0010);
      @(posedge clk);
      #1;
      check("to_locked_set", 32'(locked), 32'd1);
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         req = 4'b1000;
         #1;
         check($sformatf("to_ready_idle%0d", k), 32'(ready), 32'd0);
         @(posedge clk);
         #1;
         check($sformatf("to_locked_idle%0d", k), 32'(locked), (k < 16) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      #1;
      check("to_req3_ready", 32'(ready), 32'b1000);
      @(posedge clk);
      #1;
      check("to_req3_byte",  32'(tx_data), 32'h33);
      check("to_req3_owner", 32'(owner),   32'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Round-robin arbiter that shares one `uart_tx` instance between `NUM_REQ` byte producers (e.g. `uart_rx` loopback, status reporter, debug dumper). It sits between the producers and `uart_tx`. It presents the same req/ready byte handshake on both sides and holds one registered output byte. Optional line locking keeps a multi-byte message from one producer unbroken on the wire.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, legal 2..8.
- `LOCK_CHAR`, 8'h0A: terminator byte that releases a line lock. Used only with the lock feature.
- `LOCK_TIMEOUT`, 100000: idle cycles after which a lock is forcibly released. Legal 1..2^20-1. Used only with the lock feature.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset_` input 1: asynchronous, active-low reset.
- `req` input NUM_REQ: per-requester byte valid.
- `ready` output NUM_REQ: per-requester accept. At most one bit is high.
- `data` input 8*NUM_REQ: requester i drives bits [8i+7:8i].
- `tx_req` output 1: byte valid to `uart_tx`.
- `tx_ready` input 1: `uart_tx` accept.
- `tx_data` output 8: byte to `uart_tx`.
- `owner` output 3: index of the requester whose byte was most recently accepted.
- `locked` output 1: a line lock is active (always 0 when the feature is compiled out).

## Operation
- Transfer rule, both sides: a byte moves on a rising edge where req and ready are both high. Requesters hold req and data stable until accepted. Requesters must not make req depend on ready.
- Output stage: one register (`tx_req`, `tx_data`).
  - EMPTY: `tx_req`=0.
  - FULL: `tx_req`=1.
  - The stage can load when it is EMPTY or when `tx_ready`=1 (drain and refill in the same cycle).
- Arbitration, combinational in-cycle:
  - Eligible set = requesters with `req`=1, restricted to the lock owner while `locked`=1.
  - Winner = first eligible index searching `owner`+1, `owner`+2, … modulo NUM_REQ. `owner` itself is searched last.
  - `ready[winner]` = 1 only if the output stage can load. All other `ready` bits are 0.
- On accept from requester i:
  - `tx_data` <= the byte from i; `tx_req` <= 1.
  - `owner` <= i.
- On `tx_ready`=1 with no accept: `tx_req` <= 0.
- Simultaneous drain and accept: the new byte replaces the old one and `tx_req` stays 1. No bubble.
- Requests from non-winners are not lost. They wait with req held.
- Reset: asynchronous assertion clears state immediately, mid-byte or not. The byte held in the output register is discarded.
  - Reset values: `tx_req`=0, `tx_data`=8'h00, `ready`=0, `owner`=NUM_REQ-1 (so index 0 wins first), `locked`=0, timeout counter 0.
  - Deassertion is expected to be synchronised externally, as with `sync_reset`.

## Timing
- Latency from accept to `tx_req` high is 1 cycle.
- Throughput is 1 byte per cycle when `tx_ready` is held high.
- `ready` is a combinational function of `req`, `tx_req`, `tx_ready`, `owner` and lock state. There are no combinational paths from `data`.
- Wrap-around: `owner`=NUM_REQ-1 searches from index 0.
- Fairness: with all requesters continuously requesting, each gets exactly 1 byte per NUM_REQ accepts (without a lock).
- Lock timeout counter (feature on only):
  - Counts cycles where `locked`=1 and the owner's req=0.
  - Resets to 0 on any accept from the owner.
  - At LOCK_TIMEOUT it sets `locked`<=0 and clears itself.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined:
  - An accept from i of a byte ≠ LOCK_CHAR sets `locked`=1 with owner i.
  - An accept of LOCK_CHAR, or expiry of the timeout, clears `locked` the next cycle.
  - Accepting LOCK_CHAR while unlocked leaves `locked`=0.
- Not defined:
  - Every byte is arbitrated independently.
  - `locked` is tied 0.
  - The LOCK_CHAR and LOCK_TIMEOUT parameters are ignored and no counter is instantiated.

## Test plan
- Reset state: assert `reset_`=0 mid-transfer with `tx_req`=1 -> in the same cycle `tx_req`=0, `ready`=0, `locked`=0. After release, with all req=1 and `tx_ready`=1, the first accept is index 0.
- Round-robin: NUM_REQ=4, all req=1, each requester sends its index as data, `tx_ready`=1 -> `tx_data` sequence is 00,01,02,03,00, one per cycle, with `tx_req` continuously 1.
- Backpressure: `tx_ready`=0 for 10 cycles with req[2]=1, data=8'hA5 -> exactly one accept, `tx_data`=A5 held with `tx_req`=1, `ready`=0 thereafter. `tx_ready`=1 for 1 cycle -> byte drains, req[2]'s next byte is accepted that same cycle.
- Lock (`UART_TX_ARB_LOCK_EN`): req1 sends "AB\n", req0 requests continuously -> wire order 'A','B',0x0A, then req0's byte. `locked`=1 from after 'A' until the cycle after 0x0A.
- Lock timeout (`UART_TX_ARB_LOCK_EN`, LOCK_TIMEOUT=16): req1 sends 'A' then drops req, req3 waits -> `locked` falls 16 idle cycles later and req3 is accepted on the next eligible cycle.
- Feature off: repeat the lock stimulus -> interleaved order 'A', req0 byte, 'B', req0 byte, 0x0A, and `locked` stays 0.
